// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and default widths for the two-port memory arbiter.
//   resp_src_t : which requester owns the read data returning next cycle
//   port_t     : requester identity, used for round-robin bookkeeping
//   sat_inc    : saturating increment helper for the contention counter
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;
    localparam int MEM_CNT_W  = 16;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_F    = 2'd1,
        RESP_D    = 2'd2
    } resp_src_t;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Count up by one, sticking at all-ones instead of wrapping.
    function automatic logic [MEM_CNT_W-1:0] sat_inc(input logic [MEM_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port to one-port arbiter in front of a single shared memory with a
// registered (1-cycle latency) read port. Fetch reads (F) and load/store
// accesses (D) are serialised onto the memory bus, one access per cycle,
// and returning read data is steered to whichever port issued the read.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   f_req/f_addr            fetch read request
//   f_ready                 fetch request accepted this cycle
//   f_valid/f_rdata         fetch read data, one cycle after acceptance
//   d_req/d_we/d_addr/d_wdata  load/store request
//   d_ready                 data request accepted this cycle
//   d_valid/d_rdata         load read data, one cycle after acceptance
//   mem_enable/mem_we/mem_addr/mem_wdata  memory command bus
//   mem_rdata               memory read data (registered inside the memory)
//   conflict_count          saturating count of cycles where both ports requested
//
// Configuration
//   MEM_ARB_RR_EN  defined   : round-robin between F and D on contention
//                  undefined : fixed priority, D beats F
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = MEM_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_count
);

    logic              grant_f;
    logic              grant_d;
    logic              grant_any;
    resp_src_t         resp_src;

    // Last driven command, replayed on the bus while idle so the memory
    // inputs do not toggle needlessly.
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Read data is held per port between responses.
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

`ifdef MEM_ARB_RR_EN
    port_t             last_grant;
`endif

    // ------------------------------------------------------------------
    // Grant selection. Nothing is granted while reset is high.
    // ------------------------------------------------------------------
    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
`ifdef MEM_ARB_RR_EN
            if (f_req && d_req) begin
                // Contention: hand the bus to whichever port did not get it last.
                grant_d = (last_grant == PORT_F);
                grant_f = (last_grant == PORT_D);
            end else begin
                grant_d = d_req;
                grant_f = f_req;
            end
`else
            grant_d = d_req;
            grant_f = f_req && !d_req;
`endif
        end
    end

    assign grant_any = grant_f | grant_d;
    assign f_ready   = grant_f;
    assign d_ready   = grant_d;

    // ------------------------------------------------------------------
    // Memory command bus
    // ------------------------------------------------------------------
    always_comb begin
        mem_enable = grant_any;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_we     = we_q;
        if (grant_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
        end else if (grant_f) begin
            mem_addr  = f_addr;
            mem_wdata = d_wdata;
            mem_we    = 1'b0;
        end
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // Bus hold registers carry no reset: they are only observable while
    // mem_enable is low, where their contents are don't-care to the memory.
    always_ff @(posedge clock) begin
        if (grant_any) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            we_q    <= mem_we;
        end
    end

    // ------------------------------------------------------------------
    // Response tracking: remember who owns the data arriving next cycle.
    // Writes complete at acceptance and never produce a response.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_src <= RESP_NONE;
        end else if (grant_d && !d_we) begin
            resp_src <= RESP_D;
        end else if (grant_f) begin
            resp_src <= RESP_F;
        end else begin
            resp_src <= RESP_NONE;
        end
    end

    assign f_valid = (resp_src == RESP_F);
    assign d_valid = (resp_src == RESP_D);

    // Pass memory data straight through on the response cycle; otherwise
    // keep showing the last value this port received.
    always_ff @(posedge clock) begin
        if (f_valid) begin
            f_rdata_q <= mem_rdata;
        end
        if (d_valid) begin
            d_rdata_q <= mem_rdata;
        end
    end

    assign f_rdata = f_valid ? mem_rdata : f_rdata_q;
    assign d_rdata = d_valid ? mem_rdata : d_rdata_q;

`ifdef MEM_ARB_RR_EN
    // Updated on every grant, single requests included, so a lone requester
    // still yields to the other port at the next contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= PORT_F;
        end else if (grant_d) begin
            last_grant <= PORT_D;
        end else if (grant_f) begin
            last_grant <= PORT_F;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Contention counter: counts request overlap, not stalls, and sticks
    // at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (f_req && d_req && !(&conflict_count)) begin
            conflict_count <= conflict_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scenarios followed by a randomized phase, all checked against a
// transaction-level reference model (shadow memory + expected response).
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ready;
    logic        f_valid;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic        d_valid;
    logic [15:0] d_rdata;
    logic        mem_enable;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] conflict_count;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .f_req          (f_req),
        .f_addr         (f_addr),
        .f_ready        (f_ready),
        .f_valid        (f_valid),
        .f_rdata        (f_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ready        (d_ready),
        .d_valid        (d_valid),
        .d_rdata        (d_rdata),
        .mem_enable     (mem_enable),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .conflict_count (conflict_count)
    );

    // Power-up contents of the memory, as a function of address.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'hABCD;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Behavioural memory: registered read port, write on enable&we.
    logic [15:0] mem_wr [int];
    always @(posedge clock) begin
        if (mem_enable) begin
            mem_rdata <= mem_wr.exists(int'(mem_addr)) ? mem_wr[int'(mem_addr)] : init_val(mem_addr);
            if (mem_we) mem_wr[int'(mem_addr)] = mem_wdata;
        end
    end

    // ---------------- reference model state ----------------
    logic [15:0] ref_wr [int];
    int          m_pend      = 0;      // 0 none, 1 fetch, 2 data
    logic [15:0] m_pend_data = '0;
    logic [15:0] m_cnt       = '0;
    bit          m_last_d    = 0;
    logic [15:0] m_addr      = '0;
    bit          m_addr_known = 0;
    logic [15:0] m_fdata = '0, m_ddata = '0;
    bit          m_f_known = 0, m_d_known = 0;
    bit          last_fg = 0, last_dg = 0;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check everything visible in the cycle, then advance
    // the model across the rising edge.
    task automatic cycle();
        bit egf, egd;
        @(negedge clock);
        egf = 0;
        egd = 0;
        if (!reset) begin
            if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                if (m_last_d) egf = 1; else egd = 1;
`else
                egd = 1;
`endif
            end else if (d_req) egd = 1;
            else if (f_req) egf = 1;
        end
        chk("f_ready", f_ready, egf);
        chk("d_ready", d_ready, egd);
        chk("mem_enable", mem_enable, egf | egd);
        if (reset) chk("mem_we_rst", mem_we, 0);
        if (egf || egd) begin
            chk("mem_we", mem_we, egd & d_we);
            chk("mem_addr", mem_addr, egd ? d_addr : f_addr);
            chk("mem_wdata", mem_wdata, d_wdata);
        end else if (m_addr_known) begin
            chk("mem_addr_hold", mem_addr, m_addr);
        end
        chk("f_valid", f_valid, m_pend == 1);
        chk("d_valid", d_valid, m_pend == 2);
        if (m_pend == 1) chk("f_rdata", f_rdata, m_pend_data);
        else if (m_f_known) chk("f_rdata_hold", f_rdata, m_fdata);
        if (m_pend == 2) chk("d_rdata", d_rdata, m_pend_data);
        else if (m_d_known) chk("d_rdata_hold", d_rdata, m_ddata);
        chk("conflict_count", conflict_count, m_cnt);

        // advance model
        if (m_pend == 1) begin m_fdata = m_pend_data; m_f_known = 1; end
        if (m_pend == 2) begin m_ddata = m_pend_data; m_d_known = 1; end
        m_pend = 0;
        if (reset) begin
            m_cnt    = '0;
            m_last_d = 0;
        end else begin
            if (f_req && d_req && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
            if (egd) begin
                if (d_we) ref_wr[int'(d_addr)] = d_wdata;
                else begin m_pend = 2; m_pend_data = ref_read(d_addr); end
                m_addr = d_addr;
            end else if (egf) begin
                m_pend = 1;
                m_pend_data = ref_read(f_addr);
                m_addr = f_addr;
            end
            if (egf || egd) begin
                m_last_d     = egd;
                m_addr_known = 1;
            end
        end
        last_fg = egf;
        last_dg = egd;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit exp_pat [4];
        reset   = 1'b1;
        f_req   = 1'b0;
        f_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        // Reset state
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_f_valid", f_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_count", conflict_count, 0);

        // 1: lone fetch read
        f_req  = 1'b1;
        f_addr = 16'h0010;
        cycle();
        f_req = 1'b0;
        chk("t1_f_valid", f_valid, 1);
        chk("t1_f_rdata", f_rdata, 16'hABCD);
        chk("t1_d_valid", d_valid, 0);
        cycle();

        // 2: write then read same address back-to-back
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0020;
        d_wdata = 16'h1234;
        cycle();
        d_we = 1'b0;
        cycle();
        d_req = 1'b0;
        chk("t2_d_valid", d_valid, 1);
        chk("t2_d_rdata", d_rdata, 16'h1234);
        cycle();

        // 3: contention for four cycles
        reset = 1'b1;
        cycle();
        reset  = 1'b0;
        f_req  = 1'b1;
        f_addr = 16'h0040;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0041;
`ifdef MEM_ARB_RR_EN
        exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_grant_d", d_ready, exp_pat[i]);
            cycle();
        end
        f_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk("t3_count", conflict_count, 4);
        cycle();

        // 4: reset the cycle after a data read is granted
        d_req  = 1'b1;
        d_addr = 16'h0030;
        cycle();
        d_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("t4_mem_enable_rst", mem_enable, 0);
        chk("t4_mem_we_rst", mem_we, 0);
        cycle();
        reset = 1'b0;
        chk("t4_d_valid", d_valid, 0);
        chk("t4_count", conflict_count, 0);
        cycle();

        // 5: drive the counter to saturation and beyond
        f_req  = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        f_addr = 16'h0005;
        d_addr = 16'h0006;
        for (int i = 0; i < 65540; i++) cycle();
        f_req = 1'b0;
        d_req = 1'b0;
        chk("t5_count_sat", conflict_count, 16'hFFFF);
        cycle();

        // 6: back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            f_req  = 1'b1;
            f_addr = 16'(i);
            cycle();
            chk("t6_f_valid", f_valid, 1);
            chk("t6_f_rdata", f_rdata, init_val(16'(i)));
        end
        f_req = 1'b0;
        cycle();

        // Randomized traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            if (f_req && !last_fg) begin
                if ($urandom_range(0, 9) == 0) f_req = 1'b0;
            end else begin
                f_req  = 1'($urandom_range(0, 1));
                f_addr = 16'($urandom_range(0, 15));
            end
            if (d_req && !last_dg) begin
                if ($urandom_range(0, 9) == 0) d_req = 1'b0;
            end else begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 15));
                d_wdata = 16'($urandom);
            end
            cycle();
        end
        reset = 1'b0;
        f_req = 1'b0;
        d_req = 1'b0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
